exe_stage: RTL and testbench

Execute pipeline stage of the LoongArch single-issue core. It registers one instruction from decode through a valid/allowin handshake and drives the alu with the registered operands and the 12-bit one-hot operation. It produces the memory-stage payload and issues the data SRAM request for loads and stores. It also exports forwarding and load-use hazard information back to decode.

---
 rtl/exe_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_exe_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage of the single-issue LoongArch core.
// Holds one instruction from decode and runs it through the ALU.
// Hands the result to the memory stage, issues the data SRAM request
// for word loads/stores, and reports forwarding/load-use info to decode.

// Integer ALU, selected by a 12-bit one-hot operation vector.
// An all-zero operation vector yields 0.
module exe_alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic        op_add;
  logic        op_sub;
  logic        op_slt;
  logic        op_sltu;
  logic        op_and;
  logic        op_nor;
  logic        op_or;
  logic        op_xor;
  logic        op_sll;
  logic        op_srl;
  logic        op_sra;
  logic        op_lui;

  assign op_add  = alu_op[0];
  assign op_sub  = alu_op[1];
  assign op_slt  = alu_op[2];
  assign op_sltu = alu_op[3];
  assign op_and  = alu_op[4];
  assign op_nor  = alu_op[5];
  assign op_or   = alu_op[6];
  assign op_xor  = alu_op[7];
  assign op_sll  = alu_op[8];
  assign op_srl  = alu_op[9];
  assign op_sra  = alu_op[10];
  assign op_lui  = alu_op[11];

  logic        use_sub;
  logic [31:0] adder_b;
  logic [32:0] adder_sum;
  logic [31:0] add_sub_res;
  logic [31:0] slt_res;
  logic [31:0] sltu_res;
  logic [31:0] and_res;
  logic [31:0] nor_res;
  logic [31:0] or_res;
  logic [31:0] xor_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;
  logic [31:0] lui_res;
  logic [4:0]  shamt;

  // One shared adder serves add, sub and both compares (a + ~b + 1 for the latter three).
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    use_sub   = op_sub | op_slt | op_sltu;
    adder_b   = use_sub ? ~alu_src2 : alu_src2;
    adder_sum = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, use_sub};
    add_sub_res = adder_sum[31:0];

    // Signed less-than: differing signs decide directly, equal signs use the difference sign.
    slt_res      = 32'd0;
    slt_res[0]   = (alu_src1[31] & ~alu_src2[31])
                 | (~(alu_src1[31] ^ alu_src2[31]) & adder_sum[31]);

    // Unsigned less-than: a - b borrows exactly when there is no carry out.
    sltu_res     = 32'd0;
    sltu_res[0]  = ~adder_sum[32];

    and_res = alu_src1 & alu_src2;
    nor_res = ~(alu_src1 | alu_src2);
    or_res  = alu_src1 | alu_src2;
    xor_res = alu_src1 ^ alu_src2;

    shamt   = alu_src2[4:0];
    sll_res = alu_src1 << shamt;
    srl_res = alu_src1 >> shamt;
    sra_res = $unsigned($signed(alu_src1) >>> shamt);

    // Decode has already placed the shifted 20-bit immediate in operand 2.
    lui_res = alu_src2;
  end

  // AND-OR result select; with a one-hot vector exactly one term survives, with zero none does.
  always_comb begin
    alu_result = ({32{op_add | op_sub}} & add_sub_res)
               | ({32{op_slt}}          & slt_res)
               | ({32{op_sltu}}         & sltu_res)
               | ({32{op_and}}          & and_res)
               | ({32{op_nor}}          & nor_res)
               | ({32{op_or}}           & or_res)
               | ({32{op_xor}}          & xor_res)
               | ({32{op_sll}}          & sll_res)
               | ({32{op_srl}}          & srl_res)
               | ({32{op_sra}}          & sra_res)
               | ({32{op_lui}}          & lui_res);
  end

endmodule

// Execute pipeline stage: valid/allowin handshake, ALU, SRAM request, forwarding.
module exe_stage (
  input  logic        clk,
  input  logic        reset,

  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [31:0] ds_pc,
  input  logic [11:0] ds_alu_op,
  input  logic [31:0] ds_alu_src1,
  input  logic [31:0] ds_alu_src2,
  input  logic [31:0] ds_rkd_value,
  input  logic        ds_mem_we,
  input  logic        ds_res_from_mem,
  input  logic        ds_gr_we,
  input  logic [4:0]  ds_dest,

  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic [31:0] es_alu_result,
  output logic        es_res_from_mem,
  output logic        es_gr_we,
  output logic [4:0]  es_dest,

  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,

  output logic        es_fwd_valid,
  output logic [4:0]  es_fwd_dest,
  output logic [31:0] es_fwd_data,
  output logic        es_load_block
);

  typedef struct packed {
    logic [31:0] pc;
    logic [11:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic        mem_we;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
  } es_payload_t;

  logic        es_valid_q;
  logic        es_valid_d;
  es_payload_t es_q;
  es_payload_t es_d;

  logic        es_ready_go;
  logic        fire;
  logic        es_load_go;

  // Execution always completes in one cycle.
  assign es_ready_go    = 1'b1;
  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign es_load_go     = ds_to_es_valid && es_allowin;

  // Next-state: valid follows decode whenever the slot frees; payload only on a real accept.
  always_comb begin
    es_valid_d = es_valid_q;
    es_d       = es_q;
    if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
    end
    if (es_load_go) begin
      es_d.pc           = ds_pc;
      es_d.alu_op       = ds_alu_op;
      es_d.src1         = ds_alu_src1;
      es_d.src2         = ds_alu_src2;
      es_d.rkd_value    = ds_rkd_value;
      es_d.mem_we       = ds_mem_we;
      es_d.res_from_mem = ds_res_from_mem;
      es_d.gr_we        = ds_gr_we;
      es_d.dest         = ds_dest;
    end
  end

  // Stage registers; reset dominates any handshake in flight.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      es_valid_q <= 1'b0;
      // NOTE: the payload is cleared as well so es_pc, es_dest and the SRAM address read 0 out of reset.
      es_q       <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      es_q       <= es_d;
    end
  end

  exe_alu u_alu (
    .alu_op     (es_q.alu_op),
    .alu_src1   (es_q.src1),
    .alu_src2   (es_q.src2),
    .alu_result (es_alu_result)
  );

  // Memory-stage payload comes straight from the registers.
  assign es_pc           = es_q.pc;
  assign es_res_from_mem = es_q.res_from_mem;
  assign es_gr_we        = es_q.gr_we;
  assign es_dest         = es_q.dest;

  // The SRAM request is issued only in the handoff cycle, so read data lines up
  // with the instruction once it sits in the memory stage.
  assign fire            = es_valid_q && ms_allowin;
  assign data_sram_en    = (es_q.res_from_mem || es_q.mem_we) && fire;
  assign data_sram_we    = {4{es_q.mem_we && fire}};
  assign data_sram_addr  = es_alu_result;
  assign data_sram_wdata = es_q.rkd_value;

  // r0 is hardwired to zero, so a write to it never needs to be forwarded.
  assign es_fwd_valid  = es_valid_q && es_q.gr_we && (es_q.dest != 5'd0);
  assign es_fwd_dest   = es_q.dest;
  assign es_fwd_data   = es_alu_result;
  assign es_load_block = es_fwd_valid && es_q.res_from_mem;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic [31:0] ds_pc;
  logic [11:0] ds_alu_op;
  logic [31:0] ds_alu_src1;
  logic [31:0] ds_alu_src2;
  logic [31:0] ds_rkd_value;
  logic        ds_mem_we;
  logic        ds_res_from_mem;
  logic        ds_gr_we;
  logic [4:0]  ds_dest;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic [31:0] es_alu_result;
  logic        es_res_from_mem;
  logic        es_gr_we;
  logic [4:0]  es_dest;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        es_fwd_valid;
  logic [4:0]  es_fwd_dest;
  logic [31:0] es_fwd_data;
  logic        es_load_block;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_to_es_valid  (ds_to_es_valid),
    .es_allowin      (es_allowin),
    .ds_pc           (ds_pc),
    .ds_alu_op       (ds_alu_op),
    .ds_alu_src1     (ds_alu_src1),
    .ds_alu_src2     (ds_alu_src2),
    .ds_rkd_value    (ds_rkd_value),
    .ds_mem_we       (ds_mem_we),
    .ds_res_from_mem (ds_res_from_mem),
    .ds_gr_we        (ds_gr_we),
    .ds_dest         (ds_dest),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_pc           (es_pc),
    .es_alu_result   (es_alu_result),
    .es_res_from_mem (es_res_from_mem),
    .es_gr_we        (es_gr_we),
    .es_dest         (es_dest),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .es_fwd_valid    (es_fwd_valid),
    .es_fwd_dest     (es_fwd_dest),
    .es_fwd_data     (es_fwd_data),
    .es_load_block   (es_load_block)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      12'h008: return (a < b) ? 32'd1 : 32'd0;
      12'h010: return a & b;
      12'h020: return ~(a | b);
      12'h040: return a | b;
      12'h080: return a ^ b;
      12'h100: return a << b[4:0];
      12'h200: return a >> b[4:0];
      12'h400: return $unsigned($signed(a) >>> b[4:0]);
      12'h800: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Model: the one instruction the stage holds, if any.
  bit          m_valid;
  logic [31:0] m_pc;
  logic [11:0] m_op;
  logic [31:0] m_s1;
  logic [31:0] m_s2;
  logic [31:0] m_rkd;
  bit          m_st;
  bit          m_ld;
  bit          m_gw;
  logic [4:0]  m_dest;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b0;
      m_pc = '0; m_op = '0; m_s1 = '0; m_s2 = '0; m_rkd = '0;
      m_st = 1'b0; m_ld = 1'b0; m_gw = 1'b0; m_dest = '0;
    end else if (!m_valid || ms_allowin) begin
      // The slot is free (empty or handing off): take whatever decode offers.
      if (ds_to_es_valid) begin
        m_pc = ds_pc; m_op = ds_alu_op; m_s1 = ds_alu_src1; m_s2 = ds_alu_src2;
        m_rkd = ds_rkd_value; m_st = ds_mem_we; m_ld = ds_res_from_mem;
        m_gw = ds_gr_we; m_dest = ds_dest;
      end
      m_valid = ds_to_es_valid;
    end
  end

  // Compare every output against the model each cycle, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] res;
      bit          handoff;
      bit          fwd;
      res     = ref_alu(m_op, m_s1, m_s2);
      handoff = m_valid && ms_allowin;
      fwd     = m_valid && m_gw && (m_dest != 5'd0);
      check("m_allowin",    32'(es_allowin),      32'(!m_valid || ms_allowin));
      check("m_to_ms",      32'(es_to_ms_valid),  32'(m_valid));
      check("m_pc",         es_pc,                m_pc);
      check("m_result",     es_alu_result,        res);
      check("m_res_mem",    32'(es_res_from_mem), 32'(m_ld));
      check("m_gr_we",      32'(es_gr_we),        32'(m_gw));
      check("m_dest",       32'(es_dest),         32'(m_dest));
      check("m_sram_en",    32'(data_sram_en),    32'((m_ld || m_st) && handoff));
      check("m_sram_we",    32'(data_sram_we),    (m_st && handoff) ? 32'hF : 32'h0);
      check("m_sram_addr",  data_sram_addr,       res);
      check("m_sram_wdata", data_sram_wdata,      m_rkd);
      check("m_fwd_valid",  32'(es_fwd_valid),    32'(fwd));
      check("m_fwd_dest",   32'(es_fwd_dest),     32'(m_dest));
      check("m_fwd_data",   es_fwd_data,          res);
      check("m_load_block", 32'(es_load_block),   32'(fwd && m_ld));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] rkd, input logic st, input logic ld,
                           input logic gw, input logic [4:0] dest, input logic [31:0] pc);
    ds_to_es_valid  = 1'b1;
    ds_alu_op       = op;
    ds_alu_src1     = s1;
    ds_alu_src2     = s2;
    ds_rkd_value    = rkd;
    ds_mem_we       = st;
    ds_res_from_mem = ld;
    ds_gr_we        = gw;
    ds_dest         = dest;
    ds_pc           = pc;
  endtask

  // Bubble with garbage payload: the stage must ignore it.
  task automatic set_bubble();
    ds_to_es_valid  = 1'b0;
    ds_alu_op       = 12'($urandom);
    ds_alu_src1     = $urandom;
    ds_alu_src2     = $urandom;
    ds_rkd_value    = $urandom;
    ds_mem_we       = 1'($urandom);
    ds_res_from_mem = 1'($urandom);
    ds_gr_we        = 1'($urandom);
    ds_dest         = 5'($urandom);
    ds_pc           = $urandom;
  endtask

  logic [11:0] s_op  [4];
  logic [31:0] s_s1  [4];
  logic [31:0] s_s2  [4];
  logic [31:0] s_exp [4];

  initial begin
    reset      = 1'b1;
    ms_allowin = 1'b1;
    set_bubble();
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_allowin", 32'(es_allowin),     32'd1);
      check("idle_to_ms",   32'(es_to_ms_valid), 32'd0);
      check("idle_sram_en", 32'(data_sram_en),   32'd0);
      check("idle_fwd",     32'(es_fwd_valid),   32'd0);
      check("idle_pc",      es_pc,               32'd0);
      cyc();
    end

    // add wraps around.
    set_instr(OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h100);
    cyc();
    set_bubble();
    @(negedge clk);
    check("add_result", es_alu_result,       32'h0000_0001);
    check("add_fwd",    32'(es_fwd_valid),   32'd1);
    check("add_dest",   32'(es_fwd_dest),    32'd4);
    check("add_block",  32'(es_load_block),  32'd0);

    // Store stalled by the memory stage for three cycles, decode holding a load.
    set_instr(OP_ADD, 32'h1000, 32'h8, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 5'd3, 32'h104);
    cyc();
    set_instr(OP_ADD, 32'h2000, 32'h4, 32'h0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h108);
    ms_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_en",      32'(data_sram_en),   32'd0);
      check("stall_allowin", 32'(es_allowin),     32'd0);
      check("stall_addr",    data_sram_addr,      32'h1008);
      check("stall_wdata",   data_sram_wdata,     32'hDEAD_BEEF);
      check("stall_pc",      es_pc,               32'h104);
      check("stall_fwd",     32'(es_fwd_valid),   32'd0);
      cyc();
    end
    ms_allowin = 1'b1;
    @(negedge clk);
    check("st_en",    32'(data_sram_en), 32'd1);
    check("st_we",    32'(data_sram_we), 32'hF);
    check("st_addr",  data_sram_addr,    32'h1008);
    check("st_wdata", data_sram_wdata,   32'hDEAD_BEEF);
    cyc();

    // Load to r7 entered on the same edge the store left.
    set_instr(OP_ADD, 32'h3000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h10C);
    @(negedge clk);
    check("ld7_pc",    es_pc,               32'h108);
    check("ld7_block", 32'(es_load_block),  32'd1);
    check("ld7_en",    32'(data_sram_en),   32'd1);
    check("ld7_we",    32'(data_sram_we),   32'd0);
    check("ld7_addr",  data_sram_addr,      32'h2004);
    cyc();
    set_bubble();
    @(negedge clk);
    check("ld0_fwd",   32'(es_fwd_valid),   32'd0);
    check("ld0_block", 32'(es_load_block),  32'd0);
    check("ld0_en",    32'(data_sram_en),   32'd1);
    cyc();

    // Back-to-back stream at full throughput.
    s_op[0] = OP_SRA;  s_s1[0] = 32'h8000_0000; s_s2[0] = 32'd4;          s_exp[0] = 32'hF800_0000;
    s_op[1] = OP_SLTU; s_s1[1] = 32'd1;         s_s2[1] = 32'd2;          s_exp[1] = 32'd1;
    s_op[2] = OP_SLT;  s_s1[2] = 32'hFFFF_FFFF; s_s2[2] = 32'd1;          s_exp[2] = 32'd1;
    s_op[3] = OP_LUI;  s_s1[3] = 32'h1234_5678; s_s2[3] = 32'hABCD_E000; s_exp[3] = 32'hABCD_E000;
    for (int i = 0; i < 4; i++) begin
      set_instr(s_op[i], s_s1[i], s_s2[i], 32'd0, 1'b0, 1'b0, 1'b1, 5'(i + 1), 32'h200 + 32'(4 * i));
      cyc();
      @(negedge clk);
      check("stream_result", es_alu_result,      s_exp[i]);
      check("stream_valid",  32'(es_to_ms_valid), 32'd1);
      check("stream_pc",     es_pc,              32'h200 + 32'(4 * i));
    end
    set_bubble();
    cyc();
    @(negedge clk);
    check("stream_drain", 32'(es_to_ms_valid), 32'd0);

    // Reset while a stalled store is held.
    set_instr(OP_ADD, 32'h40, 32'h4, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 5'd0, 32'h300);
    cyc();
    set_bubble();
    ms_allowin = 1'b0;
    @(negedge clk);
    check("rst_held", 32'(es_to_ms_valid), 32'd1);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    ms_allowin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_valid", 32'(es_to_ms_valid), 32'd0);
      check("rst_we",    32'(data_sram_we),   32'd0);
      check("rst_en",    32'(data_sram_en),   32'd0);
      cyc();
    end

    // Randomized traffic, checked every cycle by the model comparator.
    for (int n = 0; n < 3000; n++) begin
      int kind;
      int k;
      logic [11:0] op;
      reset      = ($urandom_range(0, 199) == 0);
      ms_allowin = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        k    = $urandom_range(0, 12);
        op   = (k == 12) ? 12'h000 : (12'h001 << k);
        kind = $urandom_range(0, 2);
        set_instr(op, $urandom, $urandom, $urandom,
                  kind == 2, kind == 1, (kind == 1) || ((kind == 0) && ($urandom_range(0, 3) != 0)),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), $urandom);
      end else begin
        set_bubble();
      end
      cyc();
    end
    reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
